// File: rtl/pot_scan_seq.sv
// Round-robin A2D sequencer: sweeps NUM_CH slots through A2D_intf and holds one registered result per slot.
// Define POT_SMOOTH_EN to replace direct loads with a first-order IIR (pot += (res - pot) >>> SMOOTH_SH).
module pot_scan_seq #(
    parameter int unsigned          NUM_CH    = 6,
    parameter int unsigned          RES_W     = 12,
    parameter logic [3*NUM_CH-1:0]  CH_MAP    = 18'o732401,
    parameter int unsigned          GAP_CYC   = 0,
    parameter int unsigned          SMOOTH_SH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     cnv_cmplt,
    input  logic [RES_W-1:0]         res,
    output logic                     strt_cnv,
    output logic [2:0]               chnnl,
    output logic [NUM_CH*RES_W-1:0]  pot,
    output logic [NUM_CH-1:0]        pot_upd,
    output logic                     sweep_done
);

    localparam int unsigned       GAP_W     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [2:0]        SLOT_LAST = 3'(NUM_CH - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

    state_t                          state_q, state_d;
    logic [2:0]                      slot_q, slot_d;
    logic [GAP_W-1:0]                gap_cnt_q, gap_cnt_d;
    logic [NUM_CH-1:0][RES_W-1:0]    pot_q, pot_d;
    logic [NUM_CH-1:0]               pot_upd_q, pot_upd_d;
    logic                            sweep_done_q, sweep_done_d;

`ifdef POT_SMOOTH_EN
    logic [NUM_CH-1:0]               primed_q, primed_d;

    // Difference is taken one bit wider and shifted arithmetically (floor), so the
    // step never overshoots the sample and the RES_W-bit sum cannot wrap.
    function automatic logic [RES_W-1:0] smooth(input logic [RES_W-1:0] cur,
                                                input logic [RES_W-1:0] smp);
        logic signed [RES_W:0] diff;
        logic signed [RES_W:0] step;
        diff = $signed({1'b0, smp}) - $signed({1'b0, cur});
        step = diff >>> SMOOTH_SH;
        return cur + RES_W'(step);
    endfunction
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        slot_d       = slot_q;
        gap_cnt_d    = gap_cnt_q;
        pot_d        = pot_q;
        pot_upd_d    = '0;
        sweep_done_d = 1'b0;
        strt_cnv     = 1'b0;
        chnnl        = 3'd0;
`ifdef POT_SMOOTH_EN
        primed_d     = primed_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_START;
            end

            S_START: begin
                strt_cnv = 1'b1;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (3'(i) == slot_q) chnnl = CH_MAP[3*i +: 3];
                end
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (cnv_cmplt) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (3'(i) == slot_q) begin
`ifdef POT_SMOOTH_EN
                            pot_d[i]    = primed_q[i] ? smooth(pot_q[i], res) : res;
                            primed_d[i] = 1'b1;
`else
                            pot_d[i]    = res;
`endif
                            pot_upd_d[i] = 1'b1;
                        end
                    end
                    // A low en stops the sweep after this capture; re-enabling restarts at slot 0.
                    if (slot_q == SLOT_LAST) begin
                        sweep_done_d = 1'b1;
                        slot_d       = 3'd0;
                        if (GAP_CYC > 0) begin
                            state_d   = S_GAP;
                            gap_cnt_d = '0;
                        end else begin
                            state_d = en ? S_START : S_IDLE;
                        end
                    end else begin
                        slot_d  = en ? slot_q + 3'd1 : 3'd0;
                        state_d = en ? S_START : S_IDLE;
                    end
                end
            end

            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = en ? S_START : S_IDLE;
                else                       gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            slot_q       <= 3'd0;
            gap_cnt_q    <= '0;
            // NOTE: the result registers are reset too; downstream logic must never see stale values.
            pot_q        <= '0;
            pot_upd_q    <= '0;
            sweep_done_q <= 1'b0;
`ifdef POT_SMOOTH_EN
            primed_q     <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q      <= state_d;
            slot_q       <= slot_d;
            gap_cnt_q    <= gap_cnt_d;
            pot_q        <= pot_d;
            pot_upd_q    <= pot_upd_d;
            sweep_done_q <= sweep_done_d;
`ifdef POT_SMOOTH_EN
            primed_q     <= primed_d;
`endif
        end
    end

    assign pot        = pot_q;
    assign pot_upd    = pot_upd_q;
    assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_pot_scan_seq.sv
// Self-checking bench for pot_scan_seq: a default six-slot instance and a one-slot, three-cycle-gap instance,
// each driven by an A2D model and checked every cycle against a slot-level reference model.
module tb_pot_scan_seq;

`ifdef POT_SMOOTH_EN
    localparam bit SMOOTH = 1'b1;
`else
    localparam bit SMOOTH = 1'b0;
`endif
    localparam int SMOOTH_SH = 2;

    logic        clk;
    logic        rst_n;
    logic        en0, en1;
    logic        cmplt0 = 1'b0, cmplt1 = 1'b0;
    logic [11:0] res0 = '0, res1 = '0;
    logic        strt0, strt1;
    logic [2:0]  ch0, ch1;
    logic [71:0] pot0;
    logic [11:0] pot1;
    logic [5:0]  upd0;
    logic [0:0]  upd1;
    logic        done0, done1;

    pot_scan_seq u_dut (
        .clk(clk), .rst_n(rst_n), .en(en0), .cnv_cmplt(cmplt0), .res(res0),
        .strt_cnv(strt0), .chnnl(ch0), .pot(pot0), .pot_upd(upd0), .sweep_done(done0)
    );

    pot_scan_seq #(.NUM_CH(1), .CH_MAP(3'd5), .GAP_CYC(3)) u_gap (
        .clk(clk), .rst_n(rst_n), .en(en1), .cnv_cmplt(cmplt1), .res(res1),
        .strt_cnv(strt1), .chnnl(ch1), .pot(pot1), .pot_upd(upd1), .sweep_done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model, per instance ----------------
    int          nch_c   [2] = '{6, 1};
    int          gap_c   [2] = '{0, 3};
    logic [23:0] map_c   [2] = '{24'o732401, 24'o5};
    int          pot_m   [2][8];
    bit          primed_m[2][8];
    bit          busy    [2];
    bit          gen     [2];
    bit          deliv_gen[2];
    bit          prev_rst[2];
    int          cnt     [2];
    int          cur_slot[2];
    int          exp_slot[2];
    int          exp_strt[2] = '{-1, -1};
    int          last_res[2];
    logic [2:0]  cur_ch  [2];
    int          cap_cnt [2];
    int          sweep_cnt[2];
    int          step = 0;
    int          mode = 0;  // 0: res=ch*0x100 after 20, 1: random, 2: all 0, 3: all 0xFFF

    function automatic logic [2:0] map_ch(input int i, input int s);
        return 3'(map_c[i] >> (3 * s));
    endfunction

    function automatic int pick_lat();
        case (mode)
            0:       return 20;
            1:       return int'($urandom_range(6, 1));
            default: return 3;
        endcase
    endfunction

    function automatic logic [11:0] pick_res(input int i);
        case (mode)
            0:       return 12'(int'(cur_ch[i]) * 256);
            1:       return 12'($urandom);
            2:       return 12'h000;
            default: return 12'hFFF;
        endcase
    endfunction

    task automatic apply_capture(input int i, input int s, input int r);
        int p, d, dv, q;
        p = pot_m[i][s];
        if (SMOOTH && primed_m[i][s]) begin
            d  = r - p;
            dv = 1 << SMOOTH_SH;
            q  = (d >= 0) ? d / dv : -((-d + dv - 1) / dv);
            p  = p + q;
        end else begin
            p = r;
        end
        primed_m[i][s] = 1'b1;
        pot_m[i][s]    = p;
    endtask

    task automatic step_inst(input int i, input logic rstv, input logic enb, input logic strt,
                             input logic [2:0] ch, input logic [7:0] upd, input logic [95:0] potv,
                             input logic done, output logic cmplt, output logic [11:0] r);
        logic [7:0]  exp_upd;
        logic [95:0] exp_pot;
        logic        exp_done;
        logic        was_busy;
        int          s;
        exp_upd  = '0;
        exp_done = 1'b0;
        if (!rstv) begin
            for (int k = 0; k < 8; k++) begin
                pot_m[i][k]    = 0;
                primed_m[i][k] = 1'b0;
            end
            exp_slot[i] = 0;
            exp_strt[i] = -1;
            gen[i]      = 1'b0;
        end else if (deliv_gen[i]) begin
            s = cur_slot[i];
            apply_capture(i, s, last_res[i]);
            exp_upd[s] = 1'b1;
            exp_done   = (s == nch_c[i] - 1);
            cap_cnt[i]++;
            if (exp_done) sweep_cnt[i]++;
            exp_slot[i] = (exp_done || !enb) ? 0 : s + 1;
            exp_strt[i] = !enb ? -1 : (exp_done ? step + gap_c[i] : step);
        end
        if (rstv && !prev_rst[i] && enb) exp_strt[i] = step;
        if (!enb && exp_strt[i] > step) exp_strt[i] = -1;
        prev_rst[i] = rstv;

        exp_pot = '0;
        for (int k = 0; k < nch_c[i]; k++) exp_pot[k*12 +: 12] = 12'(pot_m[i][k]);
        check($sformatf("pot[%0d]", i), potv, exp_pot);
        check($sformatf("pot_upd[%0d]", i), upd, exp_upd);
        check($sformatf("sweep_done[%0d]", i), done, exp_done);
        if (exp_strt[i] == step) check($sformatf("strt_due[%0d]", i), strt, 1'b1);

        // A2D behaviour
        was_busy     = busy[i];
        cmplt        = 1'b0;
        r            = 12'($urandom);
        deliv_gen[i] = 1'b0;
        if (busy[i]) begin
            cnt[i]--;
            if (cnt[i] == 0) begin
                busy[i]      = 1'b0;
                cmplt        = 1'b1;
                r            = pick_res(i);
                last_res[i]  = int'(r);
                deliv_gen[i] = gen[i];
            end
        end
        if (strt) begin
            check($sformatf("no_overlap[%0d]", i), was_busy, 1'b0);
            check($sformatf("chnnl[%0d]", i), ch, map_ch(i, exp_slot[i]));
            busy[i]     = 1'b1;
            gen[i]      = rstv;
            cnt[i]      = pick_lat();
            cur_slot[i] = exp_slot[i];
            cur_ch[i]   = ch;
        end
        // Spurious completion while the gap instance is idling between sweeps.
        if (exp_done && gap_c[i] > 0 && !busy[i] && !cmplt) begin
            cmplt = 1'b1;
            r     = 12'($urandom);
        end
    endtask

    always @(posedge clk) begin
        #1;
        step++;
        step_inst(0, rst_n, en0, strt0, ch0, 8'(upd0), 96'(pot0), done0, cmplt0, res0);
        step_inst(1, rst_n, en1, strt1, ch1, 8'(upd1), 96'(pot1), done1, cmplt1, res1);
    end

    // ---------------- directed sequence ----------------
    task automatic wait_sweeps(input int i, input int n);
        int target;
        target = sweep_cnt[i] + n;
        for (int t = 0; t < n * 600 && sweep_cnt[i] < target; t++) @(negedge clk);
        check("sweep_timeout", sweep_cnt[i] >= target, 1'b1);
    endtask

    initial begin
        int          exp_ch [6];
        logic [2:0]  chs [6];
        int          nstrt, ndone, first_at, t, c0, d;
        logic [5:0]  seen_upd;
        logic [11:0] saved, prev_p;

        exp_ch = '{1, 0, 4, 2, 3, 7};
        rst_n = 1'b0; en0 = 1'b1; en1 = 1'b1; mode = 0;
        repeat (3) @(negedge clk);
        check("rst_strt0", strt0, 1'b0);
        check("rst_chnnl0", ch0, 3'd0);
        check("rst_pot0", pot0, '0);
        check("rst_upd0", upd0, '0);
        check("rst_done0", done0, 1'b0);
        check("rst_strt1", strt1, 1'b0);
        check("rst_pot1", pot1, '0);
        rst_n = 1'b1;

        // Full default sweep with res = channel * 0x100.
        nstrt = 0; ndone = 0; first_at = -1;
        for (int cyc = 0; cyc < 400 && ndone == 0; cyc++) begin
            @(negedge clk);
            if (strt0) begin
                if (nstrt < 6) chs[nstrt] = ch0;
                if (nstrt == 0) first_at = cyc;
                nstrt++;
            end
            if (upd0 != 0) check("upd_onehot", $onehot(upd0), 1'b1);
            if (done0) begin
                ndone++;
                check("done_with_slot5", upd0, 6'b100000);
                check("strt_after_sweep", strt0, 1'b1);
            end
        end
        check("first_strt_cycle", first_at, 0);
        check("sweep_count", ndone, 1);
        for (int k = 0; k < 6; k++) check($sformatf("chnnl_seq%0d", k), chs[k], exp_ch[k]);
        for (int k = 0; k < 6; k++) check($sformatf("pot_slot%0d", k), pot0[k*12 +: 12], 12'(exp_ch[k] * 256));

        // Randomised sweeps.
        mode = 1;
        wait_sweeps(0, 3);

        // Gap instance: sweep_done to next strt_cnv, spurious completion ignored.
        t = 0;
        while (!done1 && t < 300) begin @(negedge clk); t++; end
        check("gap_done_seen", done1, 1'b1);
        saved = pot1; d = 0;
        while (!strt1 && d < 20) begin @(negedge clk); d++; end
        check("gap_cycles", d, 3);
        check("gap_spurious_pot", pot1, saved);

        // Drop en while slot 2 is converting.
        t = 0;
        while (!(busy[0] && cur_slot[0] == 2) && t < 600) begin @(negedge clk); t++; end
        en0 = 1'b0;
        c0 = cap_cnt[0]; t = 0;
        while (cap_cnt[0] == c0 && t < 200) begin @(negedge clk); t++; end
        seen_upd = upd0;
        check("endrop_slot2_captured", seen_upd, 6'b000100);
        nstrt = 0;
        repeat (60) begin @(negedge clk); if (strt0) nstrt++; end
        check("endrop_no_strt", nstrt, 0);
        en0 = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!strt0 && t < 10);
        check("reenable_slot0_chnnl", ch0, 3'd1);
        wait_sweeps(0, 1);

        // Reset in the middle of a conversion; the late completion must be ignored.
        t = 0;
        while (!busy[0] && t < 200) begin @(negedge clk); t++; end
        @(negedge clk);
        en0 = 1'b0; en1 = 1'b0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_pot0", pot0, '0);
        check("midrst_upd0", upd0, '0);
        rst_n = 1'b1;
        t = 0;
        while ((busy[0] || busy[1]) && t < 100) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        check("stale_cmplt_pot0", pot0, '0);
        check("stale_cmplt_pot1", pot1, '0);

        // Smoothing walk on slot 0: 0xFFF, then zeros.
        mode = 3; en0 = 1'b1; en1 = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!strt0 && t < 10);
        check("restart_slot0_chnnl", ch0, 3'd1);
        wait_sweeps(0, 1);
        check("smooth_load", pot0[11:0], 12'hFFF);
        mode = 2;
        wait_sweeps(0, 1);
        check("smooth_step1", pot0[11:0], SMOOTH ? 12'hBFF : 12'h000);
        wait_sweeps(0, 1);
        check("smooth_step2", pot0[11:0], SMOOTH ? 12'h8FF : 12'h000);
        for (int n = 0; n < 28 && pot0[11:0] != 0; n++) begin
            prev_p = pot0[11:0];
            wait_sweeps(0, 1);
            check("smooth_no_underflow", pot0[11:0] <= prev_p, 1'b1);
        end
        check("smooth_reaches_zero", pot0[11:0], 12'h000);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
        $fatal(1);
    end

endmodule

// File: doc/pot_scan_seq.md
# pot_scan_seq

Parametrised round-robin sequencer for the slide-pot A2D. It drives `A2D_intf` (`strt_cnv`/`chnnl` out, `cnv_cmplt`/`res` in) through a configurable list of channels and holds one registered result per slot. It adds three things over the fixed six-pot scanner:

- a sweep enable,
- per-slot update strobes and an end-of-sweep strobe,
- an optional inter-sweep gap and optional exponential smoothing.

It sits between `A2D_intf` and the equalizer/volume logic.

## Interface
Parameters:
- `NUM_CH`, default 6: number of slots per sweep, range 1..8.
- `RES_W`, default 12: width of the A2D result.
- `CH_MAP`, default `18'o732401`: A2D channel for each slot, 3 bits per slot. Slot i uses bits [3i+2:3i]. The default gives slots 0..5 = channels 1,0,4,2,3,7 (LP,B1,B2,B3,HP,VOL).
- `GAP_CYC`, default 0: idle clocks between the end of one sweep and the next `strt_cnv`.
- `SMOOTH_SH`, default 2: IIR shift. Used only when `POT_SMOOTH_EN` is defined.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: continuous-sweep enable.
- `cnv_cmplt` in 1: one-cycle done pulse from `A2D_intf`.
- `res` in `RES_W`: conversion result, valid while `cnv_cmplt` is high.
- `strt_cnv` out 1: one-cycle conversion request.
- `chnnl` out 3: channel for the request, valid while `strt_cnv` is high and 0 otherwise.
- `pot` out `NUM_CH*RES_W`: slot i at bits [i*RES_W +: RES_W].
- `pot_upd` out `NUM_CH`: one-hot pulse in the cycle slot i's register takes its new value.
- `sweep_done` out 1: pulse coinciding with the last slot's `pot_upd`.

## Operation
- FSM states: IDLE, START, WAIT, GAP. A slot pointer (3 bits) and a gap counter (width fits `GAP_CYC`) are registered.
- **IDLE:** go to START when `en`=1.
- **START:**
  - assert `strt_cnv` for one cycle with `chnnl` = `CH_MAP[slot]`;
  - go to WAIT.
- **WAIT:** on `cnv_cmplt`:
  - capture `res` into `pot[slot]`, registered;
  - pulse `pot_upd[slot]`.
  - If slot = `NUM_CH`-1:
    - pulse `sweep_done` and set slot to 0;
    - go to GAP if `GAP_CYC`>0;
    - otherwise go to START if `en`, else IDLE.
  - Otherwise:
    - increment slot;
    - go to START if `en`, else IDLE with slot cleared to 0.
- **GAP:** count `GAP_CYC` clocks, then go to START if `en`, else IDLE.
- **Dropping `en`:**
  - It never aborts an in-flight conversion; the result is still captured.
  - The next enable always begins at slot 0.
- **Ignored inputs:**
  - `cnv_cmplt` outside WAIT.
  - `res` when `cnv_cmplt`=0.
- **`NUM_CH`=1:** every capture is also a `sweep_done`.
- **Reset:** all outputs and registers are asynchronously cleared, including mid-conversion. The FSM goes to IDLE with slot 0. Any A2D completion that arrives afterwards is ignored by the WAIT rule.

## Timing
- `strt_cnv` rises the cycle after reset is released if `en`=1 (IDLE→START takes 1 clock).
- Capture latency:
  - `pot[slot]`, `pot_upd` and `sweep_done` update on the clock edge after `cnv_cmplt` is sampled;
  - the next `strt_cnv` is high in that same following cycle.
- The A2D is therefore idle for 1 cycle between conversions, and `GAP_CYC`+1 cycles at the sweep boundary.
- `strt_cnv` is never asserted while a conversion is outstanding.
- Reset values: `strt_cnv`=0, `chnnl`=0, `pot`=0, `pot_upd`=0, `sweep_done`=0.

## Configuration
- Macro: `POT_SMOOTH_EN`.
- **Defined:**
  - Each slot keeps a primed bit, cleared by reset.
  - The first capture for a slot loads `res` directly and sets the primed bit.
  - Later captures compute `pot` ← `pot` + ((`res` − `pot`) >>> `SMOOTH_SH`). The difference is signed and `RES_W`+1 bits wide, with an arithmetic (floor) shift. The result always lies in [0, 2^`RES_W`−1].
  - Steady-state error is up to 2^`SMOOTH_SH`−1 LSB below the input. This is accepted.
- **Undefined:**
  - Each capture loads `res` directly.
  - There are no primed bits and `SMOOTH_SH` is unused.

## Test plan
- **Reset:** hold `rst_n`=0 with `en`=1. Every output must be 0. After release, `strt_cnv` must pulse next cycle with `chnnl`=1.
- **Full sweep (defaults):** the A2D model returns `res` = channel×0x100 after 20 cycles. The `chnnl` sequence must be 1,0,4,2,3,7. At the end `pot` slots must equal 0x100,0x000,0x400,0x200,0x300,0x700, `pot_upd` must be one-hot each time, and `sweep_done` must pulse once with the slot-5 update. The next `strt_cnv` must follow that capture by 1 cycle.
- **`en` dropped in slot 2 WAIT:** slot 2 must still be captured. No further `strt_cnv` may occur. After `en` is re-raised, the first `chnnl` must be 1 (slot 0).
- **`GAP_CYC`=3:** exactly 3 cycles must separate `sweep_done` from the next `strt_cnv`. A spurious `cnv_cmplt` injected during GAP must leave `pot` unchanged.
- **`POT_SMOOTH_EN`, `SMOOTH_SH`=2, slot 0:**
  - res 0xFFF must load 0xFFF;
  - then res 0x000 must give 0xBFF;
  - then 0x8FF;
  - 0 must be reached within 30 sweeps with no underflow.
- **Reset asserted mid-WAIT:** `pot` must return to 0. The primed bits must clear, so that under `POT_SMOOTH_EN` the first capture after reset loads `res` directly. The FSM must restart at slot 0.
